// File: rtl/mix_columns_pipe.sv
// AES MixColumns / InvMixColumns / bypass engine with valid/ready handshake.
// COLS_PER_CYCLE GF(2^8) column mappers are time-shared over the four state columns.
module mix_columns_pipe #(
  parameter int COLS_PER_CYCLE = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         i_clear,
  input  logic         i_valid,
  output logic         i_ready,
  input  logic [127:0] i_Din,
  input  logic [1:0]   i_mode,
  output logic         o_valid,
  input  logic         o_ready,
  output logic [127:0] o_Dout,
  output logic         o_busy
);

  localparam int NCYC  = 4 / COLS_PER_CYCLE;
  localparam int CNT_W = (NCYC > 1) ? $clog2(NCYC) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(NCYC - 1);

  if (!(COLS_PER_CYCLE == 1 || COLS_PER_CYCLE == 2 || COLS_PER_CYCLE == 4)) begin : g_bad_cpc
    $error("mix_columns_pipe: COLS_PER_CYCLE must be 1, 2 or 4");
  end

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [127:0]     data_q, data_d;
  logic [1:0]       mode_q, mode_d;
  logic [127:0]     dout_q, dout_d;
  logic [127:0]     dout_mix;
  logic             accept;

  function automatic logic [7:0] xt(input logic [7:0] b);
    xt = {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] mul3(input logic [7:0] b);
    mul3 = xt(b) ^ b;
  endfunction

  function automatic logic [7:0] mul9(input logic [7:0] b);
    mul9 = xt(xt(xt(b))) ^ b;
  endfunction

  function automatic logic [7:0] mulb(input logic [7:0] b);
    mulb = xt(xt(xt(b))) ^ xt(b) ^ b;
  endfunction

  function automatic logic [7:0] muld(input logic [7:0] b);
    muld = xt(xt(xt(b))) ^ xt(xt(b)) ^ b;
  endfunction

  function automatic logic [7:0] mule(input logic [7:0] b);
    mule = xt(xt(xt(b))) ^ xt(xt(b)) ^ xt(b);
  endfunction

  // Mode 11 is reserved and deliberately falls into the bypass arm.
  function automatic logic [31:0] mix_col(input logic [31:0] c, input logic [1:0] m);
    logic [7:0] a0, a1, a2, a3;
    {a0, a1, a2, a3} = c;
    case (m)
      2'b00: mix_col = {xt(a0) ^ mul3(a1) ^ a2 ^ a3,
                        a0 ^ xt(a1) ^ mul3(a2) ^ a3,
                        a0 ^ a1 ^ xt(a2) ^ mul3(a3),
                        mul3(a0) ^ a1 ^ a2 ^ xt(a3)};
      2'b01: mix_col = {mule(a0) ^ mulb(a1) ^ muld(a2) ^ mul9(a3),
                        mul9(a0) ^ mule(a1) ^ mulb(a2) ^ muld(a3),
                        muld(a0) ^ mul9(a1) ^ mule(a2) ^ mulb(a3),
                        mulb(a0) ^ muld(a1) ^ mul9(a2) ^ mule(a3)};
      default: mix_col = c;
    endcase
  endfunction

  // Columns outside the current slot keep their previous output value.
  always_comb begin
    dout_mix = dout_q;
    for (int j = 0; j < COLS_PER_CYCLE; j++) begin
      dout_mix[127 - 32*(int'(cnt_q)*COLS_PER_CYCLE + j) -: 32] =
        mix_col(data_q[127 - 32*(int'(cnt_q)*COLS_PER_CYCLE + j) -: 32], mode_q);
    end
  end

  assign i_ready = !i_clear && (state_q == IDLE || (state_q == DONE && o_ready));
  assign accept  = i_valid && i_ready;
  assign o_valid = (state_q == DONE);
  assign o_busy  = (state_q == CALC) || (state_q == DONE);
  assign o_Dout  = dout_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    data_d  = data_q;
    mode_d  = mode_q;
    dout_d  = dout_q;
    case (state_q)
      CALC: begin
        dout_d = dout_mix;
        if (cnt_q == LAST) begin
          state_d = DONE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      DONE: if (o_ready) state_d = IDLE;
      default: ;
    endcase
    if (accept) begin
      state_d = CALC;
      cnt_d   = '0;
      data_d  = i_Din;
      mode_d  = i_mode;
    end
    // Abort wins over everything; the output register is left untouched.
    if (i_clear) begin
      state_d = IDLE;
      cnt_d   = '0;
      dout_d  = dout_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      data_q  <= '0;
      mode_q  <= '0;
      dout_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      data_q  <= data_d;
      mode_q  <= mode_d;
      dout_q  <= dout_d;
    end
  end

endmodule

// File: tb/tb_mix_columns_pipe.sv
// Directed bench for mix_columns_pipe: instances with COLS_PER_CYCLE = 1, 2, 4
// (index 0, 1, 2) checked against hand-computed AES vectors.
module tb_mix_columns_pipe;

  logic         clk;
  logic         rst_n;
  logic         clr   [3];
  logic         vld   [3];
  logic         irdy  [3];
  logic [127:0] din   [3];
  logic [1:0]   mode  [3];
  logic         ovld  [3];
  logic         ordy  [3];
  logic [127:0] dout  [3];
  logic         busy  [3];

  int n_tests = 0;
  int n_fail  = 0;

  mix_columns_pipe #(.COLS_PER_CYCLE(1)) u_c1 (
    .clk(clk), .rst_n(rst_n), .i_clear(clr[0]), .i_valid(vld[0]), .i_ready(irdy[0]),
    .i_Din(din[0]), .i_mode(mode[0]), .o_valid(ovld[0]), .o_ready(ordy[0]),
    .o_Dout(dout[0]), .o_busy(busy[0]));

  mix_columns_pipe #(.COLS_PER_CYCLE(2)) u_c2 (
    .clk(clk), .rst_n(rst_n), .i_clear(clr[1]), .i_valid(vld[1]), .i_ready(irdy[1]),
    .i_Din(din[1]), .i_mode(mode[1]), .o_valid(ovld[1]), .o_ready(ordy[1]),
    .o_Dout(dout[1]), .o_busy(busy[1]));

  mix_columns_pipe #(.COLS_PER_CYCLE(4)) u_c4 (
    .clk(clk), .rst_n(rst_n), .i_clear(clr[2]), .i_valid(vld[2]), .i_ready(irdy[2]),
    .i_Din(din[2]), .i_mode(mode[2]), .o_valid(ovld[2]), .o_ready(ordy[2]),
    .o_Dout(dout[2]), .o_busy(busy[2]));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    #2;
    for (int k = 0; k < 3; k++) begin
      n_tests++;
      if (ovld[k] !== 1'b0 || busy[k] !== 1'b0 || dout[k] !== 128'h0) begin
        n_fail++;
        $display("FAIL reset_state[%0d]: got valid=%b busy=%b dout=%h, expected 0/0/0", k, ovld[k], busy[k], dout[k]);
      end
    end
    tick;
    rst_n = 1'b1;
    tick;
    for (int k = 0; k < 3; k++) begin
      n_tests++;
      if (irdy[k] !== 1'b1) begin
        n_fail++;
        $display("FAIL reset_ready[%0d]: got %b expected 1", k, irdy[k]);
      end
    end
  endtask

  task automatic test_forward;
    din[2] = 128'hdb135345_f20a225c_01010101_c6c6c6c6; mode[2] = 2'b00; vld[2] = 1'b1;
    #1;
    n_tests++;
    if (irdy[2] !== 1'b1) begin n_fail++; $display("FAIL fwd_ready: got %b expected 1", irdy[2]); end
    tick;
    vld[2] = 1'b0; din[2] = '0;
    n_tests++;
    if (ovld[2] !== 1'b0 || busy[2] !== 1'b1) begin
      n_fail++; $display("FAIL fwd_calc: got valid=%b busy=%b expected 0/1", ovld[2], busy[2]);
    end
    tick;
    n_tests++;
    if (ovld[2] !== 1'b1 || dout[2] !== 128'h8e4da1bc_9fdc589d_01010101_c6c6c6c6) begin
      n_fail++; $display("FAIL fwd_result: got valid=%b dout=%h expected 1 8e4da1bc9fdc589d01010101c6c6c6c6", ovld[2], dout[2]);
    end
    ordy[2] = 1'b1; tick; ordy[2] = 1'b0;
    n_tests++;
    if (ovld[2] !== 1'b0 || busy[2] !== 1'b0) begin
      n_fail++; $display("FAIL fwd_handoff: got valid=%b busy=%b expected 0/0", ovld[2], busy[2]);
    end
  endtask

  task automatic test_inverse;
    din[0] = 128'h8e4da1bc_9fdc589d_01010101_c6c6c6c6; mode[0] = 2'b01; vld[0] = 1'b1;
    tick;
    vld[0] = 1'b0; mode[0] = 2'b00; din[0] = '1;
    for (int c = 0; c < 4; c++) begin
      n_tests++;
      if (irdy[0] !== 1'b0 || ovld[0] !== 1'b0) begin
        n_fail++; $display("FAIL inv_calc_cycle%0d: got ready=%b valid=%b expected 0/0", c, irdy[0], ovld[0]);
      end
      tick;
    end
    n_tests++;
    if (ovld[0] !== 1'b1 || dout[0] !== 128'hdb135345_f20a225c_01010101_c6c6c6c6) begin
      n_fail++; $display("FAIL inv_result: got valid=%b dout=%h expected 1 db135345f20a225c01010101c6c6c6c6", ovld[0], dout[0]);
    end
    ordy[0] = 1'b1; tick; ordy[0] = 1'b0;
  endtask

  task automatic test_bypass;
    for (int m = 2; m < 4; m++) begin
      din[1] = 128'h00112233_44556677_8899aabb_ccddeeff; mode[1] = 2'(m); vld[1] = 1'b1;
      tick;
      vld[1] = 1'b0; din[1] = '0;
      tick; tick;
      n_tests++;
      if (ovld[1] !== 1'b1 || dout[1] !== 128'h00112233_44556677_8899aabb_ccddeeff) begin
        n_fail++; $display("FAIL bypass_mode%0d: got valid=%b dout=%h expected 1 00112233445566778899aabbccddeeff", m, ovld[1], dout[1]);
      end
      ordy[1] = 1'b1; tick; ordy[1] = 1'b0;
    end
    din[1] = 128'hd4bf5d30_2d26314c_d4d4d4d5_01010101; mode[1] = 2'b00; vld[1] = 1'b1;
    tick;
    vld[1] = 1'b0;
    tick; tick;
    n_tests++;
    if (ovld[1] !== 1'b1 || dout[1] !== 128'h046681e5_4d7ebdf8_d5d5d7d6_01010101) begin
      n_fail++; $display("FAIL fwd_fips: got valid=%b dout=%h expected 1 046681e54d7ebdf8d5d5d7d601010101", ovld[1], dout[1]);
    end
    ordy[1] = 1'b1; tick; ordy[1] = 1'b0;
  endtask

  task automatic test_back_to_back;
    din[1] = 128'hd4bf5d30_d4bf5d30_01010101_c6c6c6c6; mode[1] = 2'b00; vld[1] = 1'b1;
    tick;
    vld[1] = 1'b0;
    tick; tick;
    for (int c = 0; c < 5; c++) begin
      n_tests++;
      if (ovld[1] !== 1'b1 || irdy[1] !== 1'b0 || dout[1] !== 128'h046681e5_046681e5_01010101_c6c6c6c6) begin
        n_fail++; $display("FAIL stall_cycle%0d: got valid=%b ready=%b dout=%h expected 1 0 046681e5046681e501010101c6c6c6c6", c, ovld[1], irdy[1], dout[1]);
      end
      tick;
    end
    ordy[1] = 1'b1; vld[1] = 1'b1; mode[1] = 2'b01;
    din[1] = 128'h8e4da1bc_9fdc589d_01010101_c6c6c6c6;
    #1;
    n_tests++;
    if (irdy[1] !== 1'b1) begin n_fail++; $display("FAIL b2b_ready: got %b expected 1", irdy[1]); end
    tick;
    vld[1] = 1'b0; ordy[1] = 1'b0;
    n_tests++;
    if (ovld[1] !== 1'b0 || busy[1] !== 1'b1) begin
      n_fail++; $display("FAIL b2b_accept: got valid=%b busy=%b expected 0/1", ovld[1], busy[1]);
    end
    tick;
    n_tests++;
    if (ovld[1] !== 1'b0) begin n_fail++; $display("FAIL b2b_early: got valid=%b expected 0", ovld[1]); end
    tick;
    n_tests++;
    if (ovld[1] !== 1'b1 || dout[1] !== 128'hdb135345_f20a225c_01010101_c6c6c6c6) begin
      n_fail++; $display("FAIL b2b_result: got valid=%b dout=%h expected 1 db135345f20a225c01010101c6c6c6c6", ovld[1], dout[1]);
    end
    ordy[1] = 1'b1; tick; ordy[1] = 1'b0;
  endtask

  task automatic test_clear;
    din[0] = 128'h2d26314c_00000000_00000000_00000000; mode[0] = 2'b00; vld[0] = 1'b1;
    tick;
    vld[0] = 1'b0;
    tick;
    clr[0] = 1'b1;
    #1;
    n_tests++;
    if (irdy[0] !== 1'b0) begin n_fail++; $display("FAIL clr_ready_calc: got %b expected 0", irdy[0]); end
    tick;
    clr[0] = 1'b0;
    n_tests++;
    if (ovld[0] !== 1'b0 || busy[0] !== 1'b0 || dout[0] !== 128'h4d7ebdf8_f20a225c_01010101_c6c6c6c6) begin
      n_fail++; $display("FAIL clr_abort: got valid=%b busy=%b dout=%h expected 0 0 4d7ebdf8f20a225c01010101c6c6c6c6", ovld[0], busy[0], dout[0]);
    end
    tick;
    n_tests++;
    if (ovld[0] !== 1'b0) begin n_fail++; $display("FAIL clr_stays_idle: got valid=%b expected 0", ovld[0]); end
    clr[0] = 1'b1; vld[0] = 1'b1; mode[0] = 2'b00;
    din[0] = 128'hd4bf5d30_2d26314c_d4d4d4d5_01010101;
    #1;
    n_tests++;
    if (irdy[0] !== 1'b0) begin n_fail++; $display("FAIL clr_ready_idle: got %b expected 0", irdy[0]); end
    tick;
    clr[0] = 1'b0;
    n_tests++;
    if (busy[0] !== 1'b0) begin n_fail++; $display("FAIL clr_blocks_accept: got busy=%b expected 0", busy[0]); end
    tick;
    vld[0] = 1'b0;
    tick; tick; tick; tick;
    n_tests++;
    if (ovld[0] !== 1'b1 || dout[0] !== 128'h046681e5_4d7ebdf8_d5d5d7d6_01010101) begin
      n_fail++; $display("FAIL clr_next_block: got valid=%b dout=%h expected 1 046681e54d7ebdf8d5d5d7d601010101", ovld[0], dout[0]);
    end
    ordy[0] = 1'b1; tick; ordy[0] = 1'b0;
  endtask

  task automatic test_async_reset;
    din[2] = 128'hd4bf5d30_2d26314c_d4d4d4d5_01010101; mode[2] = 2'b00; vld[2] = 1'b1;
    tick;
    vld[2] = 1'b0;
    tick;
    n_tests++;
    if (ovld[2] !== 1'b1) begin n_fail++; $display("FAIL arst_pre_done: got valid=%b expected 1", ovld[2]); end
    #3 rst_n = 1'b0;
    #1;
    n_tests++;
    if (ovld[2] !== 1'b0 || dout[2] !== 128'h0 || busy[2] !== 1'b0) begin
      n_fail++; $display("FAIL arst_immediate: got valid=%b busy=%b dout=%h expected 0 0 0", ovld[2], busy[2], dout[2]);
    end
    #2 rst_n = 1'b1;
    tick;
    n_tests++;
    if (irdy[2] !== 1'b1 || ovld[2] !== 1'b0) begin
      n_fail++; $display("FAIL arst_release: got ready=%b valid=%b expected 1/0", irdy[2], ovld[2]);
    end
  endtask

  initial begin
    rst_n = 1'b0;
    for (int k = 0; k < 3; k++) begin
      clr[k] = 1'b0; vld[k] = 1'b0; din[k] = '0; mode[k] = '0; ordy[k] = 1'b0;
    end
    test_reset;
    test_forward;
    test_inverse;
    test_bypass;
    test_back_to_back;
    test_clear;
    test_async_reset;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/mix_columns_pipe.md
Name: mix_columns_pipe

Overview:
Parametrised, handshaked AES MixColumns engine. Supports forward MixColumns, InvMixColumns and bypass (final round), selected per block. COLS_PER_CYCLE GF(2^8) column datapaths are time-multiplexed over the 4 state columns, trading area against throughput. Sits between the ShiftRows/InvShiftRows stage and AddRoundKey in the round pipeline, with valid/ready flow control on both sides.

Parameters:
COLS_PER_CYCLE, 4, column mappers instantiated; legal values 1, 2, 4 (others: elaboration error); NCYC = 4/COLS_PER_CYCLE

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous active-low reset
i_clear  input  1  synchronous abort; drops the block in flight
i_valid  input  1  i_Din/i_mode valid
i_ready  output  1  engine can accept a block this cycle
i_Din  input  128  state; column c = bits [127-32c -: 32], byte 0 of column = MSB
i_mode  input  2  00 forward, 01 inverse, 10 bypass, 11 reserved (treated as bypass)
o_valid  output  1  o_Dout holds a finished block
o_ready  input  1  downstream accepts o_Dout
o_Dout  output  128  transformed state, same layout as i_Din
o_busy  output  1  high in CALC or DONE

Behaviour:
- Reset (rst_n low, async): state IDLE, o_Dout = 0, o_valid = 0, column counter = 0, captured data/mode = 0. i_ready = 1 on the first cycle after release.
- Forward matrix rows {02 03 01 01} rotated; inverse rows {0e 0b 0d 09} rotated. Reduction modulo x^8+x^4+x^3+x+1. xtime = shift left 1, XOR 8'h1b if bit 7 was set; 04/08 via repeated xtime; 09/0b/0d/0e as XOR sums.
- FSM states: IDLE, CALC, DONE.
- IDLE: i_ready = 1. Accept on i_valid: latch i_Din and i_mode, counter = 0, go to CALC.
- CALC: i_ready = 0. Each edge maps columns counter*COLS_PER_CYCLE .. +COLS_PER_CYCLE-1 of the latched data into the matching o_Dout columns, then counter++.
- CALC exit: on the edge that processes counter = NCYC-1, go to DONE and set o_valid = 1.
- DONE: o_valid = 1; o_Dout stable until handoff (o_valid & o_ready).
- DONE, i_ready = o_ready: handoff with i_valid high accepts the new block in the same edge and goes to CALC. Handoff without i_valid goes to IDLE.
- Latency: NCYC edges from accept edge to o_valid high. Back-to-back throughput: one block per NCYC+1 cycles.
- o_Dout updates only in CALC; columns not yet processed keep their prior values. Nothing downstream samples o_Dout while o_valid = 0.
- Mode is latched at accept. Changing i_mode mid-block has no effect.
- i_clear high: next edge forces IDLE, o_valid = 0, counter = 0; o_Dout retains its value. i_clear overrides a simultaneous accept or handoff, so nothing is accepted that edge. i_ready is 0 while i_clear is high.
- rst_n asserted mid-CALC or in DONE: immediate async return to reset values. The partial block is lost.
- Reserved mode 11 behaves exactly as bypass.
- The counter wraps to 0 on each accept. With COLS_PER_CYCLE = 4 the counter is constant 0 and CALC lasts one edge.

Test Plan:
- Forward, COLS_PER_CYCLE=4. Input columns db135345 / f20a225c / 01010101 / c6c6c6c6, mode 00 -> o_Dout = 8e4da1bc_9fdc589d_01010101_c6c6c6c6, o_valid one edge after accept.
- Inverse, COLS_PER_CYCLE=1. Input 8e4da1bc_9fdc589d_01010101_c6c6c6c6, mode 01 -> db135345_f20a225c_01010101_c6c6c6c6 after 4 edges; i_ready = 0 throughout CALC.
- Bypass, mode 10 and mode 11, input 00112233_44556677_8899aabb_ccddeeff -> identical output; FIPS-197 round-1 forward column d4bf5d30 -> 046681e5.
- Backpressure, COLS_PER_CYCLE=2. o_ready held 0 for 5 cycles in DONE -> o_Dout/o_valid stable, i_ready = 0. Then o_ready = 1 with i_valid = 1 -> handoff and new accept on the same edge; next result 2 edges later.
- i_clear pulsed in the 2nd CALC cycle (COLS_PER_CYCLE=1) -> IDLE next edge, o_valid stays 0; a following block completes correctly.
- rst_n dropped asynchronously in DONE -> o_valid and o_Dout go to 0 immediately without a clock edge; i_ready = 1 after release.
